// File: rtl/formacao_pkg.sv
// rtl/formacao_pkg.sv - shared constants and state encoding for the enemy formation controller
package formacao_pkg;

    // Enemy sprite geometry and horizontal step per movement tick
    localparam int LARGURA_INIMIGO = 33;
    localparam int ALTURA_INIMIGO  = 24;
    localparam int PASSO_X         = 2;

    typedef enum logic [1:0] {
        DIREITA  = 2'd0,
        ESQUERDA = 2'd1,
        VIRANDO  = 2'd2,
        PARADO   = 2'd3
    } estado_t;

endpackage

// File: rtl/formacao_extremos.sv
// rtl/formacao_extremos.sv - combinational min/max x over the live enemies
//
// Ports:
//   x_flat     in  10*N_INIMIGOS  enemy x values, enemy i at [10i+9:10i]
//   vivo       in  N_INIMIGOS     live flag per enemy
//   min_x      out 10             smallest x among live enemies (3FF if none)
//   max_x      out 10             largest x among live enemies (0 if none)
//   algum_vivo out 1              at least one enemy alive
module formacao_extremos
    import formacao_pkg::*;
#(
    parameter int N_INIMIGOS = 8
) (
    input  logic [10*N_INIMIGOS-1:0] x_flat,
    input  logic [N_INIMIGOS-1:0]    vivo,
    output logic [9:0]               min_x,
    output logic [9:0]               max_x,
    output logic                     algum_vivo
);

    logic [9:0] w_x;

    always_comb begin
        min_x      = 10'h3FF;
        max_x      = 10'h000;
        algum_vivo = 1'b0;
        w_x        = 10'h000;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            w_x = x_flat[10*i +: 10];
            // Dead enemies must not pull the extremes toward a border
            if (vivo[i]) begin
                algum_vivo = 1'b1;
                if (w_x < min_x) min_x = w_x;
                if (w_x > max_x) max_x = w_x;
            end
        end
    end

endmodule

// File: rtl/formacao_ctrl.sv
// rtl/formacao_ctrl.sv - enemy formation controller: shared direction, reversals, status
//
// Optional feature macro: FORMACAO_INVASAO_EN (invasion detection and PARADO freeze)
//
// Ports:
//   CLOCK_MV      in  1              movement tick clock
//   resetInimigo  in  1              asynchronous active-high reset
//   pausa         in  1              freezes state machine and counters
//   x_flat        in  10*N_INIMIGOS  enemy x values, enemy i at [10i+9:10i]
//   y_flat        in  10*N_INIMIGOS  enemy y values, same packing
//   vivo          in  N_INIMIGOS     live flag per enemy
//   sentidoX      out 1              formation direction, 1 = right
//   todos_mortos  out 1              registered, 1 when no enemy alive
//   invasao       out 1              sticky invasion flag
//   descidas      out 8              saturating reversal count
module formacao_ctrl
    import formacao_pkg::*;
#(
    parameter int N_INIMIGOS      = 8,
    parameter int X_MIN           = 8,
    parameter int X_MAX           = 632,
    parameter int Y_LIMITE        = 400,
    parameter int HOLD_CICLOS     = 2,
    parameter int SENTIDO_INICIAL = 1
) (
    input  logic                     CLOCK_MV,
    input  logic                     resetInimigo,
    input  logic                     pausa,
    input  logic [10*N_INIMIGOS-1:0] x_flat,
    input  logic [10*N_INIMIGOS-1:0] y_flat,
    input  logic [N_INIMIGOS-1:0]    vivo,
    output logic                     sentidoX,
    output logic                     todos_mortos,
    output logic                     invasao,
    output logic [7:0]               descidas
);

    localparam estado_t    ESTADO_RESET  = (SENTIDO_INICIAL != 0) ? DIREITA : ESQUERDA;
    localparam logic       SENTIDO_RESET = (SENTIDO_INICIAL != 0);
    localparam logic [2:0] HOLD_CARGA    = 3'(HOLD_CICLOS);
    // 11-bit edge arithmetic so max_x + width + step cannot wrap
    localparam logic [10:0] OFS_DIR = 11'(LARGURA_INIMIGO + PASSO_X);
    localparam logic [10:0] LIM_DIR = 11'(X_MAX);
    localparam logic [10:0] LIM_ESQ = 11'(X_MIN + PASSO_X);

    estado_t    r_estado;
    logic [2:0] r_hold;
    logic       r_sentido;
    logic [7:0] r_descidas;
    logic       r_todos_mortos;

    estado_t    w_estado_n;
    logic [2:0] w_hold_n;
    logic       w_sentido_n;
    logic [7:0] w_descidas_n;
    logic [7:0] w_descidas_inc;

    logic [9:0] w_min_x;
    logic [9:0] w_max_x;
    logic       w_algum_vivo;
    logic       w_hit_dir;
    logic       w_hit_esq;
    logic       w_invade;

    formacao_extremos #(
        .N_INIMIGOS (N_INIMIGOS)
    ) u_extremos (
        .x_flat     (x_flat),
        .vivo       (vivo),
        .min_x      (w_min_x),
        .max_x      (w_max_x),
        .algum_vivo (w_algum_vivo)
    );

    assign w_hit_dir = ({1'b0, w_max_x} + OFS_DIR) > LIM_DIR;
    assign w_hit_esq = {1'b0, w_min_x} < LIM_ESQ;

    assign w_descidas_inc = (r_descidas == 8'hFF) ? r_descidas : r_descidas + 8'd1;

`ifdef FORMACAO_INVASAO_EN
    logic r_invasao;

    always_comb begin
        w_invade = 1'b0;
        for (int i = 0; i < N_INIMIGOS; i++) begin
            if (vivo[i] && (({1'b0, y_flat[10*i +: 10]} + 11'(ALTURA_INIMIGO)) >= 11'(Y_LIMITE)))
                w_invade = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_MV or posedge resetInimigo) begin
        if (resetInimigo)
            r_invasao <= 1'b0;
        else if (!pausa && w_invade)
            r_invasao <= 1'b1;
    end

    assign invasao = r_invasao;
`else
    logic w_unused_y;

    assign w_unused_y = ^y_flat;
    assign w_invade   = 1'b0;
    assign invasao    = 1'b0;
`endif

    always_ff @(posedge CLOCK_MV or posedge resetInimigo) begin
        if (resetInimigo) begin
            r_estado       <= ESTADO_RESET;
            r_hold         <= 3'd0;
            r_sentido      <= SENTIDO_RESET;
            r_descidas     <= 8'd0;
            r_todos_mortos <= 1'b0;
        end else begin
            r_estado       <= w_estado_n;
            r_hold         <= w_hold_n;
            r_sentido      <= w_sentido_n;
            r_descidas     <= w_descidas_n;
            r_todos_mortos <= !w_algum_vivo;
        end
    end

    always_comb begin
        w_estado_n   = r_estado;
        w_hold_n     = r_hold;
        w_sentido_n  = r_sentido;
        w_descidas_n = r_descidas;
        // With nobody alive the extremes are meaningless, so everything holds
        if (!pausa && w_algum_vivo) begin
            case (r_estado)
                DIREITA: begin
                    if (w_hit_dir) begin
                        w_sentido_n  = 1'b0;
                        w_descidas_n = w_descidas_inc;
                        w_hold_n     = HOLD_CARGA;
                        w_estado_n   = VIRANDO;
                    end
                end
                ESQUERDA: begin
                    if (w_hit_esq) begin
                        w_sentido_n  = 1'b1;
                        w_descidas_n = w_descidas_inc;
                        w_hold_n     = HOLD_CARGA;
                        w_estado_n   = VIRANDO;
                    end
                end
                VIRANDO: begin
                    // Leave on the edge where the counter reaches zero
                    if (r_hold <= 3'd1) begin
                        w_hold_n   = 3'd0;
                        w_estado_n = r_sentido ? DIREITA : ESQUERDA;
                    end else begin
                        w_hold_n = r_hold - 3'd1;
                    end
                end
                PARADO: begin
                end
                default: begin
                    w_estado_n = ESTADO_RESET;
                end
            endcase
`ifdef FORMACAO_INVASAO_EN
            // Invasion overrides any reversal taken on the same edge
            if (w_invade || r_invasao) begin
                w_estado_n   = PARADO;
                w_sentido_n  = r_sentido;
                w_descidas_n = r_descidas;
                w_hold_n     = 3'd0;
            end
`endif
        end
    end

    assign sentidoX     = r_sentido;
    assign descidas     = r_descidas;
    assign todos_mortos = r_todos_mortos;

endmodule

// File: tb/tb_formacao_ctrl.sv
// tb/tb_formacao_ctrl.sv - directed self-checking bench for formacao_ctrl with 4 enemies
module tb_formacao_ctrl;

    localparam int N = 4;
`ifdef FORMACAO_INVASAO_EN
    localparam bit INV_EN = 1'b1;
`else
    localparam bit INV_EN = 1'b0;
`endif

    logic            CLOCK_MV;
    logic            resetInimigo;
    logic            pausa;
    logic [10*N-1:0] x_flat;
    logic [10*N-1:0] y_flat;
    logic [N-1:0]    vivo;
    logic            sentidoX;
    logic            todos_mortos;
    logic            invasao;
    logic [7:0]      descidas;

    int n_total = 0;
    int n_pass  = 0;

    formacao_ctrl #(
        .N_INIMIGOS (N)
    ) dut (
        .CLOCK_MV     (CLOCK_MV),
        .resetInimigo (resetInimigo),
        .pausa        (pausa),
        .x_flat       (x_flat),
        .y_flat       (y_flat),
        .vivo         (vivo),
        .sentidoX     (sentidoX),
        .todos_mortos (todos_mortos),
        .invasao      (invasao),
        .descidas     (descidas)
    );

    initial begin
        CLOCK_MV = 1'b0;
        forever #5 CLOCK_MV = ~CLOCK_MV;
    end

    function automatic logic [10*N-1:0] pack4(input int a, input int b, input int c, input int d);
        return {10'(d), 10'(c), 10'(b), 10'(a)};
    endfunction

    task automatic tick();
        @(posedge CLOCK_MV);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    initial begin
        resetInimigo = 1'b1;
        pausa        = 1'b0;
        vivo         = 4'hF;
        x_flat       = pack4(100, 200, 300, 400);
        y_flat       = pack4(100, 100, 100, 100);
        #12;
        check("rst_sentido", sentidoX, 1);
        check("rst_descidas", descidas, 0);
        check("rst_invasao", invasao, 0);
        check("rst_mortos", todos_mortos, 0);
        tick();
        resetInimigo = 1'b0;

        // Right edge: 596+35=631 is inside, 598+35=633 hits
        x_flat = pack4(100, 200, 300, 596);
        tick();
        check("dir596_sentido", sentidoX, 1);
        check("dir596_descidas", descidas, 0);
        x_flat = pack4(100, 200, 300, 598);
        tick();
        check("dir598_sentido", sentidoX, 0);
        check("dir598_descidas", descidas, 1);
        tick();
        check("hold1_sentido", sentidoX, 0);
        check("hold1_descidas", descidas, 1);
        tick();
        check("hold2_sentido", sentidoX, 0);
        check("hold2_descidas", descidas, 1);

        // Left edge: 9 < 8+2
        x_flat = pack4(9, 200, 300, 400);
        tick();
        check("esq9_sentido", sentidoX, 1);
        check("esq9_descidas", descidas, 2);
        x_flat = pack4(100, 200, 300, 500);
        tick();
        tick();

        // Dead enemy at 620 must be ignored
        vivo   = 4'b0111;
        x_flat = pack4(100, 200, 500, 620);
        tick();
        tick();
        check("mask_sentido", sentidoX, 1);
        check("mask_descidas", descidas, 2);

        // Nobody alive: status set, state held even with a hitting x
        vivo   = 4'b0000;
        x_flat = pack4(100, 200, 300, 600);
        tick();
        check("mortos_flag", todos_mortos, 1);
        check("mortos_sentido", sentidoX, 1);
        check("mortos_descidas", descidas, 2);

        // Pause with a right hit pending
        vivo  = 4'hF;
        pausa = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("pausa_sentido", sentidoX, 1);
        end
        check("pausa_mortos", todos_mortos, 0);
        check("pausa_descidas", descidas, 2);
        pausa = 1'b0;
        tick();
        check("solta_sentido", sentidoX, 0);
        check("solta_descidas", descidas, 3);

        // Asynchronous reset in the middle of a turn
        #2;
        resetInimigo = 1'b1;
        #1;
        check("rstmid_sentido", sentidoX, 1);
        check("rstmid_descidas", descidas, 0);
        check("rstmid_invasao", invasao, 0);
        check("rstmid_mortos", todos_mortos, 0);
        tick();
        resetInimigo = 1'b0;
        tick();
        check("posrst_sentido", sentidoX, 0);
        check("posrst_descidas", descidas, 1);

        // Invasion: 375+24=399 below line, 376+24=400 on it
        #2;
        resetInimigo = 1'b1;
        tick();
        resetInimigo = 1'b0;
        x_flat = pack4(100, 200, 300, 400);
        y_flat = pack4(100, 100, 375, 100);
        tick();
        check("inv375", invasao, 0);
        check("inv375_sentido", sentidoX, 1);
        y_flat = pack4(100, 100, 376, 100);
        tick();
        check("inv376", invasao, INV_EN ? 1 : 0);
        x_flat = pack4(100, 200, 300, 600);
        tick();
        check("inv_sentido", sentidoX, INV_EN ? 1 : 0);
        check("inv_descidas", descidas, INV_EN ? 0 : 1);
        check("inv_sticky", invasao, INV_EN ? 1 : 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
